pe_result_drain16: RTL and testbench

Downstream stage of a row of `processingElement16` MAC units. It counts accepted MAC steps per output window and, after `KERNEL_LEN` steps, captures every PE's FP16 accumulator into a local buffer. It pulses `pe_clear` to zero the accumulators, then streams the buffered results out one per cycle over a valid/ready interface, with an optional ReLU applied. It also throttles the upstream operand feeder through `mac_ready` whenever the buffer cannot accept a new window.

---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_relu.sv | 12 +
 rtl/pe_result_drain16.sv | 116 +++++++++++
 tb/tb_pe_result_drain16.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 types and constants for the PE result path.
// Used by the drain stage and the reusable ReLU.
package fp16_pkg;

  localparam int          FP16_SIGN_BIT = 15;
  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    ACCUM,
    SETTLE,
    CAPTURE
  } drain_state_t;

endpackage

// File: rtl/fp16_relu.sv
// Combinational FP16 ReLU.
// Any word with the sign bit set, including -0, -inf and negative NaN, maps to +0.
module fp16_relu
  import fp16_pkg::*;
(
  input  fp16_t word,
  output fp16_t rectified
);

  assign rectified = word[FP16_SIGN_BIT] ? FP16_POS_ZERO : word;

endmodule

// File: rtl/pe_result_drain16.sv
// Counts MAC steps per window, captures all PE accumulators,
// clears them, and streams the buffered results with optional ReLU.
module pe_result_drain16
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 8,
  parameter int KERNEL_LEN = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mac_valid,
  output logic                       mac_ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_results,
  input  logic                       relu_en,
  output logic                       pe_clear,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy
);

  localparam int CW = $clog2(KERNEL_LEN + 1);
  localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  localparam logic [CW-1:0] LAST_STEP = CW'(KERNEL_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PE - 1);

  drain_state_t  state;
  logic [CW-1:0] stepCnt;
  fp16_t         bufMem [NUM_PE];
  logic          bufFull;
  logic          reluQ;
  logic [IW-1:0] rdIdx;

  logic  stepFire;
  logic  drainFire;
  logic  lastFire;
  fp16_t headWord;
  fp16_t reluWord;

  assign mac_ready = (state == ACCUM);
  assign pe_clear  = (state == CAPTURE);
  assign busy      = (state != ACCUM) || bufFull;

  assign stepFire  = mac_valid && mac_ready;
  assign drainFire = bufFull && out_ready;
  assign lastFire  = drainFire && (rdIdx == LAST_IDX);

  assign headWord  = bufMem[rdIdx];

  fp16_relu uRelu (
    .word      (headWord),
    .rectified (reluWord)
  );

  assign out_valid = bufFull;
  assign out_last  = bufFull && (rdIdx == LAST_IDX);
  assign out_data  = reluQ ? reluWord : headWord;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ACCUM;
      stepCnt <= '0;
      bufFull <= 1'b0;
      rdIdx   <= '0;
      reluQ   <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        bufMem[i] <= FP16_POS_ZERO;
      end
    end else begin
      unique case (state)
        ACCUM: begin
          if (stepFire) begin
            if (stepCnt == LAST_STEP) begin
              stepCnt <= '0;
              state   <= SETTLE;
            end else begin
              stepCnt <= stepCnt + 1'b1;
            end
          end
        end
        // The word leaving on this edge frees the buffer for next cycle.
        SETTLE: begin
          if (!bufFull || lastFire) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= ACCUM;
        end
        default: begin
          state <= ACCUM;
        end
      endcase

      if (state == CAPTURE) begin
        bufFull <= 1'b1;
        rdIdx   <= '0;
        reluQ   <= relu_en;
        for (int i = 0; i < NUM_PE; i++) begin
          bufMem[i] <= pe_results[i*DATA_WIDTH +: 16];
        end
      end else if (drainFire) begin
        if (rdIdx == LAST_IDX) begin
          bufFull <= 1'b0;
          rdIdx   <= '0;
        end else begin
          rdIdx <= rdIdx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_result_drain16.sv
// Directed bench for pe_result_drain16 with NUM_PE=4, KERNEL_LEN=3.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_pe_result_drain16;

  localparam int NP = 4;

  logic          clk;
  logic          reset;
  logic          mac_valid;
  logic          mac_ready;
  logic [63:0]   pe_results;
  logic          relu_en;
  logic          pe_clear;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  int checks = 0;
  int passes = 0;

  pe_result_drain16 #(
    .DATA_WIDTH (16),
    .NUM_PE     (NP),
    .KERNEL_LEN (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mac_valid  (mac_valid),
    .mac_ready  (mac_ready),
    .pe_results (pe_results),
    .relu_en    (relu_en),
    .pe_clear   (pe_clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Three accepted steps; returns in the SETTLE cycle.
  task automatic feedWindow();
    mac_valid = 1'b1;
    tick();
    tick();
    tick();
    mac_valid = 1'b0;
  endtask

  // Expects NP words back-to-back starting in the current cycle.
  task automatic drainAll(input string tag, input logic [15:0] w [NP]);
    for (int i = 0; i < NP; i++) begin
      chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
      chk({tag, "_data"}, out_data, w[i]);
      chk({tag, "_last"}, {15'd0, out_last}, (i == NP - 1) ? 16'd1 : 16'd0);
      tick();
    end
    chk({tag, "_idle"}, {15'd0, out_valid}, 16'd0);
  endtask

  logic [15:0] exp4 [NP];
  logic [15:0] prevData;
  logic        prevStall;
  int          got;

  initial begin
    reset      = 1'b1;
    mac_valid  = 1'b0;
    pe_results = '0;
    relu_en    = 1'b0;
    out_ready  = 1'b0;
    void'($urandom(32'd7));
    tick();
    tick();
    chk("rst_mac_ready", {15'd0, mac_ready}, 16'd1);
    chk("rst_pe_clear", {15'd0, pe_clear}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_last", {15'd0, out_last}, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;

    // Basic window, no ReLU.
    out_ready  = 1'b1;
    pe_results = {16'h4400, 16'hC000, 16'h3C00, 16'h0000};
    feedWindow();
    chk("w1_settle_ready", {15'd0, mac_ready}, 16'd0);
    chk("w1_settle_clear", {15'd0, pe_clear}, 16'd0);
    chk("w1_settle_busy", {15'd0, busy}, 16'd1);
    tick();
    chk("w1_capture_clear", {15'd0, pe_clear}, 16'd1);
    chk("w1_capture_valid", {15'd0, out_valid}, 16'd0);
    tick();
    chk("w1_clear_pulse", {15'd0, pe_clear}, 16'd0);
    chk("w1_ready_back", {15'd0, mac_ready}, 16'd1);
    exp4 = '{16'h0000, 16'h3C00, 16'hC000, 16'h4400};
    drainAll("w1", exp4);

    // ReLU window.
    relu_en    = 1'b1;
    pe_results = {16'h8000, 16'hFE00, 16'hC000, 16'h3C00};
    feedWindow();
    tick();
    chk("w2_capture_clear", {15'd0, pe_clear}, 16'd1);
    tick();
    relu_en = 1'b0;
    exp4 = '{16'h3C00, 16'h0000, 16'h0000, 16'h0000};
    drainAll("w2_relu", exp4);

    // Consumer stalled across two windows.
    out_ready  = 1'b0;
    pe_results = {16'h4500, 16'h4400, 16'h4200, 16'h4000};
    feedWindow();
    tick();
    chk("w3_capture_clear", {15'd0, pe_clear}, 16'd1);
    tick();
    chk("w3_first_valid", {15'd0, out_valid}, 16'd1);
    pe_results = {16'h5300, 16'h5200, 16'h5100, 16'h5000};
    feedWindow();
    for (int i = 0; i < 3; i++) begin
      chk("w4_stall_ready", {15'd0, mac_ready}, 16'd0);
      chk("w4_stall_clear", {15'd0, pe_clear}, 16'd0);
      chk("w4_stall_busy", {15'd0, busy}, 16'd1);
      chk("w4_stall_data", out_data, 16'h4000);
      chk("w4_stall_valid", {15'd0, out_valid}, 16'd1);
      tick();
    end
    out_ready = 1'b1;
    exp4 = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};
    for (int i = 0; i < NP; i++) begin
      chk("w3_drain_data", out_data, exp4[i]);
      chk("w3_drain_clear", {15'd0, pe_clear}, 16'd0);
      tick();
    end
    chk("w4_capture_clear", {15'd0, pe_clear}, 16'd1);
    chk("w4_capture_valid", {15'd0, out_valid}, 16'd0);
    tick();
    exp4 = '{16'h5000, 16'h5100, 16'h5200, 16'h5300};
    drainAll("w4", exp4);

    // mac_valid held through SETTLE and CAPTURE.
    pe_results = {16'h3800, 16'h3400, 16'h3000, 16'h2C00};
    mac_valid  = 1'b1;
    tick();
    tick();
    tick();
    chk("w5_settle_ready", {15'd0, mac_ready}, 16'd0);
    chk("w5_settle_clear", {15'd0, pe_clear}, 16'd0);
    tick();
    chk("w5_capture_clear", {15'd0, pe_clear}, 16'd1);
    tick();
    chk("w6_step1_clear", {15'd0, pe_clear}, 16'd0);
    chk("w6_step1_ready", {15'd0, mac_ready}, 16'd1);
    tick();
    chk("w6_step2_ready", {15'd0, mac_ready}, 16'd1);
    tick();
    chk("w6_step3_ready", {15'd0, mac_ready}, 16'd1);
    tick();
    chk("w6_settle_ready", {15'd0, mac_ready}, 16'd0);
    chk("w6_settle_clear", {15'd0, pe_clear}, 16'd0);
    mac_valid = 1'b0;
    tick();
    chk("w6_capture_clear", {15'd0, pe_clear}, 16'd1);
    tick();
    exp4 = '{16'h2C00, 16'h3000, 16'h3400, 16'h3800};
    drainAll("w6", exp4);

    // Random backpressure.
    pe_results = {16'h4B00, 16'h4A00, 16'h4900, 16'h4800};
    exp4 = '{16'h4800, 16'h4900, 16'h4A00, 16'h4B00};
    out_ready  = 1'b0;
    feedWindow();
    tick();
    tick();
    got       = 0;
    prevStall = 1'b0;
    prevData  = 16'h0000;
    for (int c = 0; c < 80 && got < NP; c++) begin
      out_ready = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (prevStall) begin
        chk("rnd_stable_valid", {15'd0, out_valid}, 16'd1);
        chk("rnd_stable_data", out_data, prevData);
      end
      if (out_valid && out_ready) begin
        chk("rnd_word", out_data, exp4[got]);
        chk("rnd_last", {15'd0, out_last},
            (got == NP - 1) ? 16'd1 : 16'd0);
        got++;
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      tick();
    end
    chk("rnd_word_count", 16'(got), 16'(NP));
    chk("rnd_idle", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset mid-drain with a partial window counted.
    out_ready  = 1'b1;
    pe_results = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    feedWindow();
    tick();
    tick();
    mac_valid = 1'b1;
    tick();
    mac_valid = 1'b0;
    chk("rst_mid_word1", out_data, 16'h3333);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_mid_ready", {15'd0, mac_ready}, 16'd1);
    chk("rst_mid_clear", {15'd0, pe_clear}, 16'd0);
    chk("rst_mid_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("rst_hold_clear", {15'd0, pe_clear}, 16'd0);
    reset = 1'b0;
    pe_results = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
    mac_valid  = 1'b1;
    tick();
    tick();
    chk("post_rst_step2_ready", {15'd0, mac_ready}, 16'd1);
    tick();
    mac_valid = 1'b0;
    chk("post_rst_settle", {15'd0, mac_ready}, 16'd0);
    tick();
    chk("post_rst_capture", {15'd0, pe_clear}, 16'd1);
    tick();
    exp4 = '{16'h8888, 16'h7777, 16'h6666, 16'h5555};
    drainAll("post_rst", exp4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
